// File: rtl/conv2_act_sequencer_if.sv
// Stream-in / buffer-write bundle for the conv layer 2 output sequencer.
// slave is the sequencer side, master is the PE-array / output-buffer side.
interface conv2_act_sequencer_if #(
  parameter int PACK   = 4,
  parameter int ADDR_W = 10
);
  logic                in_valid;
  logic [15:0]         in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [8*PACK-1:0]   wr_data;
  logic                wr_ready;

  modport master (
    output in_valid, in_data, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/conv2_act_sequencer.sv
// Conv layer 2 output sequencer: quantises 16-bit accumulator samples to 8 bits,
// packs PACK bytes per word and writes them to consecutive output buffer addresses.
module conv2_act_sequencer #(
  parameter int PACK   = 4,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_pix,
  output logic              busy,
  output logic              done,
  conv2_act_sequencer_if.slave bus
);
  localparam int LW = $clog2(PACK);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [LW-1:0]     lane;
  logic [LEN_W-1:0]  remaining;
  logic [8*PACK-1:0] pack_q;
  logic [8*PACK-1:0] pack_ins;
  logic [7:0]        qbyte;
  logic              acc;
  logic              last;
  logic              word_done;
  logic              hs;

  assign qbyte = {bus.in_data[15], bus.in_data[9:3]};

  // remaining gate stops extra samples being taken while the final word waits
  assign bus.in_ready = (state == RUN) && (remaining != '0) &&
                        (!bus.wr_en || bus.wr_ready);
  assign acc       = bus.in_valid && bus.in_ready;
  assign last      = (remaining == LEN_W'(1));
  assign word_done = acc && ((lane == LW'(PACK-1)) || last);
  assign hs        = bus.wr_en && bus.wr_ready;

  always_comb begin
    pack_ins = pack_q;
    pack_ins[8*lane +: 8] = qbyte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lane        <= '0;
      remaining   <= '0;
      pack_q      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus.wr_addr <= base_addr;
            remaining   <= num_pix;
            lane        <= '0;
            pack_q      <= '0;
            busy        <= 1'b1;
            if (num_pix == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (acc) begin
            remaining <= remaining - 1'b1;
            if (word_done) begin
              bus.wr_data <= pack_ins;
              pack_q      <= '0;
              lane        <= '0;
            end else begin
              pack_q <= pack_ins;
              lane   <= lane + 1'b1;
            end
          end
          if (hs) bus.wr_addr <= bus.wr_addr + 1'b1;
          // a completing word re-arms wr_en even when the previous write retires now
          if (word_done)  bus.wr_en <= 1'b1;
          else if (hs)    bus.wr_en <= 1'b0;
          if (hs && !word_done && (remaining == '0)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv2_act_sequencer.sv
// Directed bench for conv2_act_sequencer: expected writes are queued when a job
// is launched and checked against the buffer write port as handshakes occur.
module tb_conv2_act_sequencer;
  localparam int PACK   = 4;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 12;
  localparam int DW     = 8*PACK;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  num_pix = '0;
  logic              busy;
  logic              done;
  logic              wr_rdy = 1'b1;

  conv2_act_sequencer_if #(.PACK(PACK), .ADDR_W(ADDR_W)) bus ();

  conv2_act_sequencer #(.PACK(PACK), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_pix(num_pix), .busy(busy), .done(done), .bus(bus)
  );

  assign bus.wr_ready = wr_rdy;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  logic [ADDR_W+DW-1:0] sb[$];
  logic [ADDR_W+DW-1:0] exp_w;
  logic [15:0] smp[32];

  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0, in_stall = 0;
  int last_hs_cyc = 0, done_cyc = 0, start_cyc = 0;
  bit prev_stall = 0, prev_done = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DW-1:0]     prev_data;

  int stall_req = 0, stall_len = 0;
  int stall_seen = 0, stall_left = 0;

  always @(posedge clk) cyc++;

  // write-side stall generator: arms on the first wr_en after a request
  always @(posedge clk) begin
    #1;
    if (stall_seen != stall_req && bus.wr_en) begin
      stall_left = stall_len;
      stall_seen = stall_req;
    end
    if (stall_left > 0) begin
      wr_rdy = 1'b0;
      stall_left--;
    end else begin
      wr_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_wr_en", bus.wr_en, 1);
        chk("stall_wr_addr", bus.wr_addr, prev_addr);
        chk("stall_wr_data", bus.wr_data, prev_data);
      end
      prev_stall = bus.wr_en && !bus.wr_ready;
      prev_addr  = bus.wr_addr;
      prev_data  = bus.wr_data;
      if (bus.wr_en && bus.wr_ready) begin
        wr_cnt++;
        last_hs_cyc = cyc;
        chk("sb_nonempty_at_write", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("wr_addr", bus.wr_addr, exp_w[DW +: ADDR_W]);
          chk("wr_data", bus.wr_data, exp_w[DW-1:0]);
        end
      end
      if (bus.in_valid && busy && !bus.in_ready) in_stall++;
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
      if (start && !busy) start_cyc = cyc;
    end else begin
      prev_stall = 0;
      prev_done  = 0;
    end
  end

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
    start = 1'b1; base_addr = b; num_pix = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~b; num_pix = LEN_W'(7);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send(input logic [15:0] d);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int exp_writes, input int w0, input int d0, input bit has_writes);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    chk("done_seen", ok, 1);
    chk("busy_cleared", busy, 0);
    chk("write_count", wr_cnt - w0, exp_writes);
    chk("sb_drained", sb.size(), 0);
    if (has_writes) chk("done_after_last_write", done_cyc - last_hs_cyc, 1);
    else            chk("done_after_start", done_cyc - start_cyc, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", done_cnt - d0, 1);
  endtask

  task automatic expect_model(input logic [ADDR_W-1:0] b, input int n);
    logic [DW-1:0]     w = '0;
    logic [ADDR_W-1:0] a = b;
    int                ln = 0;
    for (int i = 0; i < n; i++) begin
      w[8*ln +: 8] = {smp[i][15], smp[i][9:3]};
      ln++;
      if (ln == PACK || i == n-1) begin
        sb.push_back({a, w});
        a  = a + 1'b1;
        w  = '0;
        ln = 0;
      end
    end
  endtask

  int w0, d0, s0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #3;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full throughput
    w0 = wr_cnt; d0 = done_cnt; s0 = in_stall;
    sb.push_back({10'h010, 32'h007F03D7});
    sb.push_back({10'h011, 32'h7F7F7F7F});
    start_job(10'h010, 12'd8);
    send(16'h8ABC); send(16'h0018); send(16'h03FF); send(16'h0000);
    for (int i = 0; i < 4; i++) send(16'h7FFF);
    wait_done(2, w0, d0, 1);
    chk("no_input_stall", in_stall - s0, 0);

    // write-side backpressure
    w0 = wr_cnt; d0 = done_cnt; s0 = in_stall;
    stall_len = 5;
    stall_req++;
    sb.push_back({10'h010, 32'h007F03D7});
    sb.push_back({10'h011, 32'h7F7F7F7F});
    start_job(10'h010, 12'd8);
    send(16'h8ABC); send(16'h0018); send(16'h03FF); send(16'h0000);
    for (int i = 0; i < 4; i++) send(16'h7FFF);
    wait_done(2, w0, d0, 1);
    chk("input_backpressured", (in_stall - s0) > 0, 1);

    // partial final word
    w0 = wr_cnt; d0 = done_cnt;
    sb.push_back({10'h020, 32'h01010101});
    sb.push_back({10'h021, 32'h00000101});
    start_job(10'h020, 12'd6);
    for (int i = 0; i < 6; i++) send(16'h0008);
    wait_done(2, w0, d0, 1);

    // zero-length job
    w0 = wr_cnt; d0 = done_cnt;
    start_job(10'h055, 12'd0);
    wait_done(0, w0, d0, 0);

    // start while busy is ignored
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 8; i++) smp[i] = 16'(i * 136 + 16'h0123);
    expect_model(10'h040, 8);
    start_job(10'h040, 12'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1; base_addr = 10'h200; num_pix = 12'd3;
      end
      send(smp[i]);
      start = 1'b0;
    end
    wait_done(2, w0, d0, 1);

    // reset mid-job
    start_job(10'h080, 12'd8);
    for (int i = 0; i < 3; i++) send(16'h1234);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_wr_en", bus.wr_en, 0);
    chk("midrst_wr_addr", bus.wr_addr, 0);
    chk("midrst_wr_data", bus.wr_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_done_after_reset", done_cnt - d0, 0);

    // fresh job after reset, address wrap at the top of the buffer
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 10; i++) smp[i] = 16'($urandom);
    expect_model(10'h3FE, 10);
    start_job(10'h3FE, 12'd10);
    for (int i = 0; i < 10; i++) send(smp[i]);
    wait_done(3, w0, d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv2_act_sequencer.md
# conv2_act_sequencer

Sequencer for conv layer 2 output. It accepts the stream of 16-bit accumulator results from the PE array and quantises each one to 8 bits with the same mapping as `Conv2Activation`: `{din[15], din[9:3]}`. It packs `PACK` bytes per word and writes the words to the layer-2 output buffer at consecutive addresses starting from a programmed base. It runs one job per `start` pulse, applies backpressure in both directions, and reports completion with a `done` pulse.

## Interface
- `PACK`, default 4: bytes per output word; must be a power of two, at least 2.
- `ADDR_W`, default 10: width of the output buffer address.
- `LEN_W`, default 12: width of the sample count.
- `clk` input, 1 bit: sole clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: job request; sampled only in IDLE.
- `base_addr` input, `ADDR_W` bits: first write address; latched on an accepted `start`.
- `num_pix` input, `LEN_W` bits: number of samples in the job; latched on an accepted `start`.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_data` input, 16 bits: accumulator result, two's complement.
- `in_ready` output, 1 bit: the block accepts `in_data` this cycle.
- `wr_en` output, 1 bit: write request to the output buffer.
- `wr_addr` output, `ADDR_W` bits: write address.
- `wr_data` output, 8·`PACK` bits: packed bytes; lane 0 is in bits [7:0].
- `wr_ready` input, 1 bit: buffer accepts the write this cycle.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse at job end.

## Operation
**States:** IDLE, RUN, DONE.

**IDLE**
- `in_ready` = 0.
- On `start` = 1:
  - latch `base_addr` into the address counter;
  - latch `num_pix` into the remaining count;
  - clear the lane counter and the pack register.
- If `num_pix` = 0, go to DONE. Otherwise go to RUN.

**RUN**
- Acceptance: a sample is accepted when `in_valid` & `in_ready`.
- `in_ready` = !pending | `wr_ready`. With this rule one sample per cycle is sustained while the buffer keeps up.
- Each accepted sample:
  - its byte `{in_data[15], in_data[9:3]}` is written into pack lane `lane`;
  - `lane` increments and the remaining count decrements.
- A word becomes pending when either:
  - lane `PACK`-1 is filled, or
  - the final sample (remaining = 1) is accepted.
- When a word becomes pending:
  - the pack register is copied into the `wr_data` register;
  - `wr_en` is set;
  - `lane` resets to 0;
  - the pack register is cleared, so unfilled lanes of a partial final word are 0.
- Write handshake:
  - `wr_en` stays high with `wr_data` and `wr_addr` stable until `wr_ready` = 1.
  - On handshake, `wr_addr` increments by 1. The address wraps modulo 2^`ADDR_W`; there is no error flag.
- Simultaneous handshake and new word: if a pending write is accepted in the same cycle that a new word completes, `wr_en` stays high with the new data and address (back-to-back writes).
- Exit: after the write handshake for the last word, go to DONE.
- Input order is kept; there is no sample reordering and no sample drop.

**DONE**
- `done` = 1 for exactly one cycle, then IDLE.
- `start` in DONE is ignored.

**General**
- `start` asserted while `busy` = 1 is ignored and not queued.
- Words per job = ceil(`num_pix`/`PACK`).
- Changes on `base_addr` or `num_pix` after latch have no effect on the running job.

## Timing
- Reset values (asynchronous assert, any state):
  - state = IDLE;
  - `in_ready`, `wr_en`, `busy`, `done` = 0;
  - `wr_addr` = 0, `wr_data` = 0;
  - all counters = 0.
- Reset mid-job abandons the job. No `done` is produced.
- `start` sampled at edge t: `busy` = 1 from t+1. `in_ready` can first be 1 in the cycle after t.
- Sample completing a word, accepted at edge t: `wr_en` = 1 from t+1. Input-to-write latency is 1 cycle.
- Final write handshake at edge t: `done` = 1 during cycle t+1; `busy` = 0 from t+2.
- For `num_pix` = 0: `start` at edge t gives `done` in cycle t+1, with no write.
- All outputs are registered except `in_ready`, which is combinational from state, pending and `wr_ready`.

## Test plan
- **Full throughput, no stall.** PACK=4, `base_addr`=0x010, `num_pix`=8, `wr_ready` held 1, samples 0x8ABC, 0x0018, 0x03FF, 0x0000, then four of 0x7FFF.
  - Write to 0x010 with `wr_data`=0x007F03D7.
  - Write to 0x011 with `wr_data`=0x7F7F7F7F.
  - `done` 1 cycle after the second write; no input stall.
- **Backpressure on the write side.** Same job, `wr_ready` = 0 for 5 cycles at the first write.
  - `wr_en`, `wr_addr`, `wr_data` stay stable for those cycles.
  - `in_ready` drops once the next word is pending.
  - No sample is lost; same two words as above.
- **Partial final word.** `num_pix`=6, all samples 0x0008.
  - Words 0x01010101, then 0x00000101.
  - Exactly 2 writes.
- **Zero-length job.** `num_pix`=0.
  - `done` pulses in the cycle after `start`.
  - `wr_en` never asserts.
- **Start while busy.** Pulse `start` during RUN with a different `base_addr`.
  - Ignored; addresses continue from the original base.
  - A single `done`.
- **Reset mid-job.** Assert `rst_n`=0 after 3 samples.
  - All outputs 0 immediately; no `done`.
  - A new job after release starts writing at its own `base_addr` with lane 0.
